// File: rtl/queue_tx_drain_pkg.sv
// Shared definitions for the queue transmit drain: default sizes, FSM state
// encoding and the integer log2 helper also used by the queue.
// Optional feature macro: QUEUE_TX_PARITY_EN (adds an even-parity bit after DATA).
package queue_tx_drain_pkg;

   localparam int unsigned DefWidth       = 8;
   localparam int unsigned DefClksPerBit  = 16;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StPop    = 3'd1,
      StLoad   = 3'd2,
      StStart  = 3'd3,
      StData   = 3'd4,
`ifdef QUEUE_TX_PARITY_EN
      StParity = 3'd5,
`endif
      StStop   = 3'd6
   } tx_state_e;

   // Smallest r such that 2**r >= value (0 for value <= 1).
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/queue_tx_drain_tx_baud_tick.sv
// Restartable modulo-CLKS_PER_BIT counter. tick marks the last cycle of a bit
// period; pre_tick marks the cycle before it so callers can register outputs
// that must line up with the final cycle of a bit.
module queue_tx_drain_tx_baud_tick
   import queue_tx_drain_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick,
   output logic pre_tick
);

   localparam int unsigned CntW = (clog2(CLKS_PER_BIT) > 0) ? clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] PreCnt  = CntW'(CLKS_PER_BIT - 2);

   logic [CntW-1:0] cnt_q;

   // Count 0..CLKS_PER_BIT-1 and wrap at each bit boundary; clear restarts at 0.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt_q <= '0;
      end else if (cnt_q == LastCnt) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   assign tick     = (cnt_q == LastCnt);
   assign pre_tick = (cnt_q == PreCnt);

endmodule

// File: rtl/queue_tx_drain.sv
// Pops words from a queue read port and serialises each as an async frame:
// start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Optional feature macro: QUEUE_TX_PARITY_EN (adds the PARITY state).
module queue_tx_drain
   import queue_tx_drain_pkg::*;
#(
   parameter int unsigned WIDTH        = DefWidth,
   parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             empty,
   input  logic [WIDTH-1:0] q_data,
   output logic             rd,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   localparam int unsigned     BitW    = clog2(WIDTH + 1);
   localparam logic [BitW-1:0] LastBit = BitW'(WIDTH);

   tx_state_e        state_q;
   logic [WIDTH-1:0] shift_q;
   logic [BitW-1:0]  bit_cnt_q;
   logic             tick;
   logic             pre_tick;
   logic             baud_clear;
   logic             next_pop;
`ifdef QUEUE_TX_PARITY_EN
   logic             parity_q;
`endif

   // Restart the bit timer so START gets a full CLKS_PER_BIT cycles.
   assign baud_clear = (state_q == StLoad);
   assign next_pop   = enable && !empty;

   queue_tx_drain_tx_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx_baud_tick (
      .clk      (clk),
      .reset    (reset),
      .clear    (baud_clear),
      .tick     (tick),
      .pre_tick (pre_tick)
   );

   // Frame sequencer; all outputs are registered for a glitch-free line.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx        <= 1'b1;
         rd        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef QUEUE_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         rd   <= 1'b0;
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (next_pop) begin
                  state_q <= StPop;
                  rd      <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            StPop: begin
               state_q <= StLoad;
            end
            StLoad: begin
               // Queue registered data_out on the POP edge, so it is valid now.
               shift_q  <= q_data;
`ifdef QUEUE_TX_PARITY_EN
               parity_q <= ^q_data;
`endif
               tx       <= 1'b0;
               state_q  <= StStart;
            end
            StStart: begin
               if (tick) begin
                  tx        <= shift_q[0];
                  shift_q   <= shift_q >> 1;
                  bit_cnt_q <= BitW'(1);
                  state_q   <= StData;
               end
            end
            StData: begin
               if (tick) begin
                  if (bit_cnt_q == LastBit) begin
`ifdef QUEUE_TX_PARITY_EN
                     tx      <= parity_q;
                     state_q <= StParity;
`else
                     tx      <= 1'b1;
                     state_q <= StStop;
`endif
                  end else begin
                     tx        <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                     bit_cnt_q <= bit_cnt_q + BitW'(1);
                  end
               end
            end
`ifdef QUEUE_TX_PARITY_EN
            StParity: begin
               if (tick) begin
                  tx      <= 1'b1;
                  state_q <= StStop;
               end
            end
`endif
            StStop: begin
               // Registered one cycle early so done is high on the final STOP cycle.
               if (pre_tick) done <= 1'b1;
               if (tick) begin
                  if (next_pop) begin
                     state_q <= StPop;
                     rd      <= 1'b1;
                  end else begin
                     state_q <= StIdle;
                     busy    <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               tx      <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_queue_tx_drain.sv
// Self-checking bench for queue_tx_drain (WIDTH=8, CLKS_PER_BIT=4).
// Honours QUEUE_TX_PARITY_EN when the design is built with it.
module tb_queue_tx_drain;

   localparam int W   = 8;
   localparam int CPB = 4;
`ifdef QUEUE_TX_PARITY_EN
   localparam int NBITS = W + 3;
`else
   localparam int NBITS = W + 2;
`endif
   localparam int FRAME = NBITS * CPB;
   localparam int LIMIT = 4 * FRAME + 20;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         enable = 1'b0;
   logic         empty = 1'b1;
   logic [W-1:0] q_data = '0;
   logic         rd, tx, busy, done;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   // Queue model and scoreboard
   logic [W-1:0] qmem[$];
   logic [W-1:0] exp_q[$];
   logic         push_req = 1'b0;
   logic [W-1:0] push_word = '0;
   int           pop_empty = 0;

   // Monitor state
   int           rd_cnt = 0;
   int           done_cnt = 0;
   int           rd_times[$];
   logic         prev_rd = 1'b0;
   bit           in_frame = 1'b0;
   int           mon_pos = 0;
   int           sb_idx = 0;
   logic [NBITS-1:0] mon_bits = '0;
   logic [W-1:0] got = '0;
   logic [W-1:0] last_got = '0;
`ifdef QUEUE_TX_PARITY_EN
   logic         last_par = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] data;
      logic         par;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   queue_tx_drain #(
      .WIDTH        (W),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .empty  (empty),
      .q_data (q_data),
      .rd     (rd),
      .tx     (tx),
      .busy   (busy),
      .done   (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic frame_bit(input logic [W-1:0] d, input int j);
      if (j == 0) return 1'b0;
      if (j <= W) return d[j-1];
`ifdef QUEUE_TX_PARITY_EN
      if (j == W + 1) return ^d;
`endif
      return 1'b1;
   endfunction

   // Queue: data_out registered on the rd edge; empty registered too.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd) begin
         if (qmem.size() == 0) pop_empty <= pop_empty + 1;
         else q_data <= qmem.pop_front();
      end
      if (push_req) begin
         qmem.push_back(push_word);
         exp_q.push_back(push_word);
      end
      empty <= (qmem.size() == 0);
   end

   // Line monitor: decodes frames mid-bit and compares against the scoreboard.
   always @(negedge clk) begin
      if (rd) begin
         rd_cnt++;
         rd_times.push_back(cyc);
         check("rd_one_cycle", prev_rd, 0);
      end
      prev_rd = rd;
      if (done) done_cnt++;
      if (in_frame && !busy) begin
         // Frame abandoned by reset: its word is lost.
         in_frame = 1'b0;
         sb_idx++;
      end else if (!in_frame) begin
         if (busy && tx == 1'b0) begin
            in_frame = 1'b1;
            mon_pos  = 0;
            mon_bits = '0;
         end
      end else begin
         mon_pos++;
         if (mon_pos % CPB == CPB / 2) mon_bits[mon_pos / CPB] = tx;
         if (mon_pos == FRAME - 1) begin
            in_frame = 1'b0;
            got      = mon_bits[W:1];
            last_got = got;
            check("start_bit", mon_bits[0], 0);
            check("stop_bit", mon_bits[NBITS-1], 1);
`ifdef QUEUE_TX_PARITY_EN
            last_par = mon_bits[W+1];
            check("parity_bit", mon_bits[W+1], ^got);
`endif
            if (sb_idx >= exp_q.size()) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_frame: got %02h, none expected", got);
            end else begin
               check("frame_data", got, exp_q[sb_idx]);
               sb_idx++;
            end
         end
      end
   end

   task automatic push(input logic [W-1:0] w);
      push_word = w;
      push_req  = 1'b1;
      @(negedge clk);
      push_req  = 1'b0;
   endtask

   task automatic wait_rd(input string name);
      int n = 0;
      while (rd !== 1'b1 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check(name, rd, 1);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done !== 1'b1 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check(name, done, 1);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   r0, d0, rt0;
      int   tx_bad, done_bad, busy_bad, low_cnt;
      logic exp_tx;

      vecs[0] = '{8'h07, 1'b1};
      vecs[1] = '{8'h03, 1'b0};
      vecs[2] = '{8'h3C, 1'b0};
      vecs[3] = '{8'h80, 1'b1};
      vecs[4] = '{8'h01, 1'b1};
      vecs[5] = '{8'hFE, 1'b1};
      vecs[6] = '{8'h5A, 1'b0};
      vecs[7] = '{8'hC3, 1'b0};

      // Reset held with enable=1 and a word queued.
      reset  = 1'b1;
      enable = 1'b1;
      push(8'hA5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_tx", tx, 1);
         check("reset_rd", rd, 0);
         check("reset_busy", busy, 0);
         check("reset_done", done, 0);
      end

      // Single word 0xA5, cycle-exact waveform.
      d0 = done_cnt;
      r0 = rd_cnt;
      reset = 1'b0;
      wait_rd("a5_rd_seen");
      check("a5_tx_at_pop", tx, 1);
      tx_bad = 0;
      done_bad = 0;
      busy_bad = 0;
      for (int i = 1; i <= FRAME + 2; i++) begin
         @(negedge clk);
         if (i == 1) check("a5_rd_width", rd, 0);
         exp_tx = (i >= 2 && i <= FRAME + 1) ? frame_bit(8'hA5, (i - 2) / CPB) : 1'b1;
         if (tx !== exp_tx) tx_bad++;
         if (done !== (i == FRAME + 1)) done_bad++;
         if (busy !== (i <= FRAME + 1)) busy_bad++;
      end
      check("a5_tx_waveform_errs", tx_bad, 0);
      check("a5_done_timing_errs", done_bad, 0);
      check("a5_busy_errs", busy_bad, 0);
      check("a5_done_count", done_cnt - d0, 1);
      check("a5_rd_count", rd_cnt - r0, 1);
      check("a5_data", last_got, 8'hA5);

      // Table of single words.
      foreach (vecs[k]) begin
         r0 = rd_cnt;
         d0 = done_cnt;
         push(vecs[k].data);
         wait_rd($sformatf("vec%0d_rd_seen", k));
         wait_done($sformatf("vec%0d_done_seen", k));
         @(negedge clk);
         check($sformatf("vec%0d_rd_count", k), rd_cnt - r0, 1);
         check($sformatf("vec%0d_done_count", k), done_cnt - d0, 1);
         check($sformatf("vec%0d_data", k), last_got, vecs[k].data);
         check($sformatf("vec%0d_busy_after", k), busy, 0);
`ifdef QUEUE_TX_PARITY_EN
         check($sformatf("vec%0d_parity", k), last_par, vecs[k].par);
`endif
      end

      // Empty queue: no pops, line stays idle.
      r0 = rd_cnt;
      low_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) low_cnt++;
      end
      check("empty_no_rd", rd_cnt - r0, 0);
      check("empty_tx_low_cycles", low_cnt, 0);

      // Back-to-back words.
      rt0 = rd_times.size();
      d0 = done_cnt;
      push(8'h00);
      push(8'hFF);
      push(8'h55);
      for (int k = 0; k < 3; k++) begin
         wait_done($sformatf("b2b_done%0d", k));
         @(negedge clk);
      end
      check("b2b_rd_count", rd_times.size() - rt0, 3);
      if (rd_times.size() - rt0 == 3) begin
         check("b2b_gap1", rd_times[rt0+1] - rd_times[rt0], FRAME + 2);
         check("b2b_gap2", rd_times[rt0+2] - rd_times[rt0+1], FRAME + 2);
      end
      check("b2b_done_count", done_cnt - d0, 3);
      check("b2b_empty_after", empty, 1);
      check("b2b_busy_after", busy, 0);

      // Reset during data bit 3 of 0x96 (bit 3 = 0).
      push(8'h96);
      wait_rd("rst_rd_seen");
      repeat (19) @(negedge clk);
      check("rst_pre_tx_bit3", tx, 0);
      d0 = done_cnt;
      reset = 1'b1;
      @(negedge clk);
      check("rst_tx_next", tx, 1);
      check("rst_busy_next", busy, 0);
      push(8'h3C);
      @(negedge clk);
      check("rst_no_done", done_cnt - d0, 0);
      reset = 1'b0;
      wait_rd("rst_after_rd_seen");
      wait_done("rst_after_done_seen");
      @(negedge clk);
      check("rst_after_data", last_got, 8'h3C);

      // Enable dropped mid-frame: frame completes, no further pop.
      r0 = rd_cnt;
      push(8'h81);
      push(8'h42);
      wait_rd("en_rd_seen");
      repeat (10) @(negedge clk);
      enable = 1'b0;
      wait_done("en_done_seen");
      repeat (FRAME + 10) @(negedge clk);
      check("en_rd_count", rd_cnt - r0, 1);
      check("en_busy_idle", busy, 0);
      check("en_data", last_got, 8'h81);
      check("en_queue_left", qmem.size(), 1);
      enable = 1'b1;
      wait_rd("en_resume_rd");
      wait_done("en_resume_done");
      @(negedge clk);
      check("en_resume_data", last_got, 8'h42);

      repeat (4) @(negedge clk);
      check("pop_while_empty", pop_empty, 0);
      check("scoreboard_drained", sb_idx, exp_q.size());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
